pipeline_cond_unit: RTL and testbench

//   Consumes the decode-stage control bundle (FlagW, PCS, RegW, MemW, NoWrite, MemtoReg, ALUSrc, ALUControl, Branch).

---
 rtl/pipeline_cond_unit.sv | 105 ++++++++++
 tb/tb_pipeline_cond_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipeline_cond_unit.sv
// pipeline_cond_unit: carries decode control through E/M/W, holds NZCV and gates every write on the condition field
module pipeline_cond_unit #(
   parameter int ALUC_W = 4,
   parameter int COND_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [COND_W-1:0] CondD,
   input  logic [1:0]        FlagWD,
   input  logic              PCSD,
   input  logic              RegWD,
   input  logic              MemWD,
   input  logic              NoWriteD,
   input  logic              MemtoRegD,
   input  logic              ALUSrcD,
   input  logic [ALUC_W-1:0] ALUControlD,
   input  logic              BranchD,
   input  logic              FlushE,
   input  logic [3:0]        ALUFlagsE,
   output logic [ALUC_W-1:0] ALUControlE,
   output logic              ALUSrcE,
   output logic              MemtoRegE,
   output logic              BranchTakenE,
   output logic [3:0]        FlagsQ,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              MemtoRegM,
   output logic              PCSrcW,
   output logic              RegWriteW,
   output logic              MemtoRegW
);
   logic [COND_W-1:0] CondE;
   logic [1:0]        FlagWE;
   logic              PCSE, RegWE, MemWE, NoWriteE, BranchE, PCSrcM;
   logic              CondExE, PCSrcE, RegWriteE, MemWriteE;
   logic              n, z, c, v;
   assign {n, z, c, v} = FlagsQ;
   always_comb begin
      case (CondE)
         4'b0000: CondExE = z;
         4'b0001: CondExE = ~z;
         4'b0010: CondExE = c;
         4'b0011: CondExE = ~c;
         4'b0100: CondExE = n;
         4'b0101: CondExE = ~n;
         4'b0110: CondExE = v;
         4'b0111: CondExE = ~v;
         4'b1000: CondExE = c & ~z;
         4'b1001: CondExE = ~c | z;
         4'b1010: CondExE = n == v;
         4'b1011: CondExE = n != v;
         4'b1100: CondExE = ~z & (n == v);
         4'b1101: CondExE = z | (n != v);
         4'b1110: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end
   assign PCSrcE       = PCSE & CondExE;
   assign RegWriteE    = RegWE & CondExE & ~NoWriteE;
   assign MemWriteE    = MemWE & CondExE;
   assign BranchTakenE = BranchE & CondExE;
   always_ff @(posedge clk) begin
      if (reset) begin
         CondE       <= '0;
         FlagWE      <= '0;
         PCSE        <= 1'b0;
         RegWE       <= 1'b0;
         MemWE       <= 1'b0;
         NoWriteE    <= 1'b0;
         MemtoRegE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= '0;
         BranchE     <= 1'b0;
         FlagsQ      <= '0;
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         MemtoRegM   <= 1'b0;
         PCSrcM      <= 1'b0;
         RegWriteW   <= 1'b0;
         MemtoRegW   <= 1'b0;
         PCSrcW      <= 1'b0;
      end else begin
         // a flushed slot becomes an always-executing no-op
         CondE       <= FlushE ? COND_W'(4'b1110) : CondD;
         FlagWE      <= FlushE ? 2'b00 : FlagWD;
         PCSE        <= ~FlushE & PCSD;
         RegWE       <= ~FlushE & RegWD;
         MemWE       <= ~FlushE & MemWD;
         NoWriteE    <= ~FlushE & NoWriteD;
         MemtoRegE   <= ~FlushE & MemtoRegD;
         ALUSrcE     <= ~FlushE & ALUSrcD;
         ALUControlE <= FlushE ? '0 : ALUControlD;
         BranchE     <= ~FlushE & BranchD;
         FlagsQ[3:2] <= FlagWE[1] & CondExE ? ALUFlagsE[3:2] : FlagsQ[3:2];
         FlagsQ[1:0] <= FlagWE[0] & CondExE ? ALUFlagsE[1:0] : FlagsQ[1:0];
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         MemtoRegM   <= MemtoRegE;
         PCSrcM      <= PCSrcE;
         RegWriteW   <= RegWriteM;
         MemtoRegW   <= MemtoRegM;
         PCSrcW      <= PCSrcM;
      end
   end
endmodule

// File: tb/tb_pipeline_cond_unit.sv
// tb_pipeline_cond_unit: directed scenarios plus random traffic against an instruction-level reference model
module tb_pipeline_cond_unit;
   typedef struct packed {
      logic [3:0] cond;
      logic [1:0] flagw;
      logic       pcs, regw, memw, nowr, mtr, alusrc, br;
      logic [3:0] aluc;
   } ins_t;

   logic       clk = 1'b0, reset = 1'b0, FlushE = 1'b0;
   logic [3:0] CondD = '0, ALUControlD = '0, ALUFlagsE = '0;
   logic [1:0] FlagWD = '0;
   logic       PCSD = 0, RegWD = 0, MemWD = 0, NoWriteD = 0, MemtoRegD = 0, ALUSrcD = 0, BranchD = 0;
   logic [3:0] ALUControlE, FlagsQ;
   logic       ALUSrcE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM;
   logic       PCSrcW, RegWriteW, MemtoRegW;
   int         n_chk = 0, n_err = 0;

   ins_t       e;
   logic [3:0] fl;
   logic       m_rw, m_mw, m_mtr, m_pcs, w_rw, w_mtr, w_pcs;

   always #5 clk = ~clk;

   pipeline_cond_unit dut (
      .clk(clk), .reset(reset), .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD),
      .MemWD(MemWD), .NoWriteD(NoWriteD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD),
      .ALUControlD(ALUControlD), .BranchD(BranchD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
      .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .MemtoRegM(MemtoRegM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pairs of codes share a predicate, the odd code inverts it
   function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
      bit nn = f[3], zz = f[2], cy = f[1], vv = f[0], base;
      case (cc[3:1])
         3'd0: base = zz;
         3'd1: base = cy;
         3'd2: base = nn;
         3'd3: base = vv;
         3'd4: base = cy && !zz;
         3'd5: base = (nn == vv);
         3'd6: base = !zz && (nn == vv);
         default: return cc == 4'he;
      endcase
      return cc[0] ? !base : base;
   endfunction

   function automatic ins_t mk(input logic [3:0] cond, input logic [1:0] flagw, input bit pcs,
                               input bit regw, input bit memw, input bit nowr, input bit br);
      ins_t t = '0;
      t.cond = cond; t.flagw = flagw; t.pcs = pcs; t.regw = regw;
      t.memw = memw; t.nowr = nowr; t.br = br;
      return t;
   endfunction

   task automatic step(input ins_t d, input bit fe, input bit rs, input logic [3:0] af);
      bit x;
      {CondD, FlagWD, PCSD, RegWD, MemWD, NoWriteD, MemtoRegD, ALUSrcD, BranchD, ALUControlD} = d;
      FlushE = fe; reset = rs; ALUFlagsE = af;
      @(posedge clk);
      if (rs) begin
         e = '0; fl = '0;
         {m_rw, m_mw, m_mtr, m_pcs, w_rw, w_mtr, w_pcs} = '0;
      end else begin
         x = cond_ok(e.cond, fl);
         {w_rw, w_mtr, w_pcs} = {m_rw, m_mtr, m_pcs};
         m_rw = e.regw && x && !e.nowr; m_mw = e.memw && x; m_mtr = e.mtr; m_pcs = e.pcs && x;
         if (e.flagw[1] && x) fl[3:2] = af[3:2];
         if (e.flagw[0] && x) fl[1:0] = af[1:0];
         e = fe ? mk(4'he, 0, 0, 0, 0, 0, 0) : d;
      end
      @(negedge clk);
      chk("aluc_e", ALUControlE, e.aluc);
      chk("alusrc_e", ALUSrcE, e.alusrc);
      chk("mtr_e", MemtoRegE, e.mtr);
      chk("brtaken_e", BranchTakenE, e.br && cond_ok(e.cond, fl));
      chk("flags", FlagsQ, fl);
      chk("rw_m", RegWriteM, m_rw);
      chk("mw_m", MemWriteM, m_mw);
      chk("mtr_m", MemtoRegM, m_mtr);
      chk("pcs_w", PCSrcW, w_pcs);
      chk("rw_w", RegWriteW, w_rw);
      chk("mtr_w", MemtoRegW, w_mtr);
   endtask

   initial begin
      ins_t nop, t;
      nop = mk(4'he, 0, 0, 0, 0, 0, 0);
      e = '0; fl = '0;
      {m_rw, m_mw, m_mtr, m_pcs, w_rw, w_mtr, w_pcs} = '0;
      @(negedge clk);
      step(nop, 0, 1, 0);
      step(nop, 0, 1, 0);
      step(nop, 0, 0, 0);
      chk("rst_flags", FlagsQ, 4'b0000);
      chk("rst_rw_w", RegWriteW, 0);
      // ADDS then flags, M and W write timing
      step(mk(4'he, 2'b11, 0, 1, 0, 0, 0), 0, 0, 0);
      step(nop, 0, 0, 4'b0100);
      chk("adds_flags", FlagsQ, 4'b0100);
      chk("adds_rw_m", RegWriteM, 1);
      step(nop, 0, 0, 0);
      chk("adds_rw_w", RegWriteW, 1);
      // CMP immediately followed by BEQ
      step(mk(4'he, 2'b11, 0, 1, 0, 1, 0), 0, 0, 0);
      step(mk(4'h0, 2'b00, 1, 0, 0, 0, 1), 0, 0, 4'b0100);
      chk("beq_taken", BranchTakenE, 1);
      chk("cmp_rw_m", RegWriteM, 0);
      step(nop, 0, 0, 0);
      step(nop, 0, 0, 0);
      chk("beq_pcs_w", PCSrcW, 1);
      // ADDEQ with Z clear must not write anything
      step(nop, 0, 1, 0);
      step(mk(4'h0, 2'b11, 0, 1, 0, 0, 0), 0, 0, 0);
      step(nop, 0, 0, 4'b1111);
      chk("addeq_rw_m", RegWriteM, 0);
      chk("addeq_flags", FlagsQ, 4'b0000);
      // ADD then flushed STR
      step(mk(4'he, 0, 0, 1, 0, 0, 0), 0, 0, 0);
      step(mk(4'he, 0, 0, 0, 1, 0, 0), 1, 0, 0);
      chk("flush_prev_rw_m", RegWriteM, 1);
      step(nop, 0, 0, 0);
      chk("str_mw_m", MemWriteM, 0);
      chk("flush_prev_rw_w", RegWriteW, 1);
      // reset beats flush and the pending flag write
      step(mk(4'he, 2'b11, 0, 1, 0, 0, 0), 0, 0, 0);
      step(nop, 1, 1, 4'b1111);
      chk("rstflush_flags", FlagsQ, 4'b0000);
      chk("rstflush_rw_m", RegWriteM, 0);
      // condition sweep via BranchTakenE
      for (int f = 0; f < 16; f++) begin
         step(mk(4'he, 2'b11, 0, 0, 0, 0, 0), 0, 0, 4'(f));
         for (int c = 0; c < 16; c++) begin
            step(mk(4'(c), 0, 0, 0, 0, 0, 1), 0, 0, 4'(f));
            chk($sformatf("cond_%0h_f%0h", c, f), BranchTakenE, cond_ok(4'(c), 4'(f)));
         end
      end
      for (int i = 0; i < 2000; i++) begin
         t = ins_t'($urandom);
         step(t, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, 4'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
